tomasulo_cdb_arb: RTL and testbench
===================================

Name: tomasulo_cdb_arb

Overview:
- Owner of the Common Data Bus (CDB). Arbitrates CDB writeback slots among REQ_N reservation stations and one long-latency external unit.
- Publishes the slot reservation vector sch_r and returns cdb_gnt to the requesting stations.
- Collects each granted unit's writeback LATENCY_N cycles later and broadcasts it as registered cdb_r.
- Sits between the station/functional-unit array and every CDB snooper (stations, ROB, register-status table).

Parameters:
- REQ_N, 4, number of reservation stations requesting CDB slots.
- LATENCY_N, 2, cycles from grant to that unit's writeback; fixed for all stations.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cdb_req  in  REQ_N  per-station slot request
- cdb_gnt  out  REQ_N  one-hot grant, combinational, same cycle as request
- rsv_vld  in  1  external-unit slot reservation request
- rsv_dly  in  $clog2(LATENCY_N+2)  reservation depth d, legal range 1..LATENCY_N+1
- rsv_ack  out  1  reservation accepted, combinational
- wb_vld  in  REQ_N+1  writeback valid; index REQ_N is the external unit
- wb_tag  in  (REQ_N+1) x $bits(tag_t)  writeback tag
- wb_wdata  in  (REQ_N+1) x $bits(word_t)  writeback data
- sch_r  out  sch_t (LATENCY_N+1 bits)  slot reservation vector
- cdb_r  out  cdb_t  registered broadcast {vld, tag, wdata}
- err_r  out  1  sticky protocol error

Behaviour:
- Reset values: sch_r=0, slot owners=0, cdb_r=0, err_r=0, round-robin pointer=0. cdb_gnt and rsv_ack are 0 whenever sch_r, cdb_req and rsv_vld are 0.
- Meaning of sch_r[k] in cycle T: a writeback is booked for cycle T+k, with a recorded owner. sch_r[0] means the owner drives wb in T.
- Every cycle the slots shift down: slot[k] <= slot[k+1], and slot[LATENCY_N] <= 0, before new bookings are applied.
- External reservation in T with depth d books wb at T+d, which lands in slot[d-1] at T+1.
  - rsv_ack = rsv_vld & legal d & slot free.
  - Slot is free when d<=LATENCY_N and ~sch_r[d]; d=LATENCY_N+1 is always free.
  - Illegal d (0 or >LATENCY_N+1): no ack, err_r set.
- Station grant in T books wb at T+LATENCY_N, landing in slot[LATENCY_N-1] with the owner = station index.
  - A grant is issued only if cdb_req is non-zero, ~sch_r[LATENCY_N], and NOT (rsv_ack & d==LATENCY_N). The external unit has priority on a shared slot.
  - At most one grant per cycle. Round-robin starting at the pointer; after granting i, pointer <= (i+1) mod REQ_N. With no grant, the pointer holds.
- Broadcast: if sch_r[0] in T with owner u:
  - wb_vld[u]=1: cdb_r <= {1, wb_tag[u], wb_wdata[u]} at T+1.
  - wb_vld[u]=0: cdb_r.vld <= 0 and err_r <= 1.
  - In all other cycles cdb_r.vld <= 0; tag and wdata hold.
- wb_vld[j]=1 for any j that is not the current slot[0] owner: err_r <= 1, and that data is ignored.
- err_r clears only on rst.
- Reset asserted mid-operation clears all bookings; in-flight writebacks are dropped with no broadcast and no error.
- Simultaneous d=LATENCY_N reservation and station requests: the reservation wins, cdb_gnt=0, and the pointer holds.

Decomposition:
- tomasulo_pkg gains:
  - sch_t, sized by the package LATENCY_N constant.
  - cdb_slot_t {vld, owner[$clog2(REQ_N+1)-1:0]}.
- tomasulo_pkg reuses the existing cdb_t, tag_t and word_t.
- One sub-module: tomasulo_rr_arb (REQ_N req, enable, one-hot gnt, pointer register). About 60 lines; the top level is about 200 lines.

Test Plan:
- Single request, LATENCY_N=2, REQ_N=4:
  - Stimulus: cdb_req=4'b0100 at T0; station 2 drives wb_tag=5, wdata=0xDEAD at T2.
  - Required response: cdb_gnt=0100 at T0; sch_r=3'b010 at T1, 3'b001 at T2; cdb_r={1,5,0xDEAD} at T3; err_r=0.
- Round-robin fairness:
  - Stimulus: cdb_req=4'b1111 held for 8 cycles, all stations driving wb correctly.
  - Required response: grants 0,1,2,3,0,1,2,3; one broadcast per cycle from T2+1 onward.
- External priority:
  - Stimulus: rsv_vld=1, rsv_dly=2 and cdb_req=4'b0001 at T0.
  - Required response: rsv_ack=1 and cdb_gnt=0 at T0; station 0 granted at T1; the external wb is broadcast at T3.
- Far reservation blocks stations:
  - Stimulus: rsv_dly=3 at T0.
  - Required response: sch_r[2]=1 at T1 and cdb_gnt=0 at T1 despite cdb_req=1111; grant resumes at T2.
- Protocol errors:
  - Stimulus: owner omits wb_vld in its slot; separately, a non-owner asserts wb_vld.
  - Required response: no cdb_r.vld for the missing writeback; err_r=1 in each case and stays set until rst.
- Reset mid-flight:
  - Stimulus: rst pulsed (asynchronous) at T1 after a T0 grant.
  - Required response: sch_r=0 immediately, no broadcast at T3, err_r=0, pointer=0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared CDB types: tags, data words, the broadcast record and the writeback slot schedule.
// Slot owner REQ_N denotes the long-latency external unit.
package tomasulo_pkg;

  localparam int CDB_REQ_N     = 4;
  localparam int CDB_LATENCY_N = 2;
  localparam int TAG_W         = 6;
  localparam int WORD_W        = 32;
  localparam int OWNER_W       = $clog2(CDB_REQ_N + 1);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  typedef logic [CDB_LATENCY_N:0] sch_t;

  typedef struct packed {
    logic               vld;
    logic [OWNER_W-1:0] owner;
  } cdb_slot_t;

  function automatic cdb_slot_t mk_slot(input int owner);
    cdb_slot_t s;
    s.vld   = 1'b1;
    s.owner = OWNER_W'(owner);
    return s;
  endfunction

endpackage

// File: rtl/tomasulo_rr_arb.sv
// Round-robin one-hot arbiter, combinational grant; pointer advances past the winner.
// With en low no grant is issued and the pointer holds.
module tomasulo_rr_arb #(
  parameter int REQ_N = 4,
  parameter int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_N-1:0] req,
  input  logic             en,
  output logic [REQ_N-1:0] gnt,
  output logic             gnt_vld,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer upward, wrapping; the first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < REQ_N; i++) begin
      idx = PTR_W'((int'(ptr_r) + i) % REQ_N);
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (gnt_vld) begin
      ptr_r <= PTR_W'((int'(gnt_idx) + 1) % REQ_N);
    end
  end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// CDB owner: books writeback slots for stations (fixed latency) and the external unit (depth d),
// then broadcasts each owner's writeback one cycle after it lands; protocol slips set sticky err_r.
module tomasulo_cdb_arb
  import tomasulo_pkg::*;
#(
  parameter int REQ_N     = CDB_REQ_N,
  parameter int LATENCY_N = CDB_LATENCY_N
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_N-1:0]                cdb_req,
  output logic [REQ_N-1:0]                cdb_gnt,
  input  logic                            rsv_vld,
  input  logic [$clog2(LATENCY_N+2)-1:0]  rsv_dly,
  output logic                            rsv_ack,
  input  logic [REQ_N:0]                  wb_vld,
  input  tag_t                            wb_tag   [REQ_N+1],
  input  word_t                           wb_wdata [REQ_N+1],
  output sch_t                            sch_r,
  output cdb_t                            cdb_r,
  output logic                            err_r
);

  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  cdb_slot_t          slot_r   [LATENCY_N+1];
  cdb_slot_t          slot_nxt [LATENCY_N+1];
  int                 dly;
  logic               d_legal;
  logic               d_free;
  logic               rsv_at_lat;
  logic               gnt_en;
  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic [OWNER_W-1:0] own;
  logic               wb_hit;
  logic               wb_miss;
  logic               stray;
  logic               err_set;

  always_comb begin
    sch_r = '0;
    for (int k = 0; k <= LATENCY_N; k++) sch_r[k] = slot_r[k].vld;
  end

  // Depth LATENCY_N+1 targets the slot that is empty after the shift, so it never conflicts.
  always_comb begin
    dly     = int'(rsv_dly);
    d_legal = (dly >= 1) && (dly <= LATENCY_N + 1);
    d_free  = 1'b1;
    for (int k = 1; k <= LATENCY_N; k++) begin
      if (dly == k && slot_r[k].vld) d_free = 1'b0;
    end
    rsv_ack    = rsv_vld && d_legal && d_free;
    rsv_at_lat = rsv_ack && (dly == LATENCY_N);
    gnt_en     = (|cdb_req) && !slot_r[LATENCY_N].vld && !rsv_at_lat;
  end

  tomasulo_rr_arb #(
    .REQ_N (REQ_N),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cdb_req),
    .en      (gnt_en),
    .gnt     (cdb_gnt),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Shift first, then drop in new bookings; the checks above guarantee their targets are empty.
  always_comb begin
    for (int k = 0; k < LATENCY_N; k++) slot_nxt[k] = slot_r[k+1];
    slot_nxt[LATENCY_N] = '0;
    if (rsv_ack) begin
      for (int k = 0; k <= LATENCY_N; k++) begin
        if (dly == k + 1) slot_nxt[k] = mk_slot(REQ_N);
      end
    end
    if (gnt_vld) slot_nxt[LATENCY_N-1] = mk_slot(int'(gnt_idx));
  end

  always_comb begin
    own     = slot_r[0].owner;
    wb_hit  = slot_r[0].vld && wb_vld[own];
    wb_miss = slot_r[0].vld && !wb_vld[own];
    stray   = 1'b0;
    for (int j = 0; j <= REQ_N; j++) begin
      if (wb_vld[j] && !(slot_r[0].vld && int'(own) == j)) stray = 1'b1;
    end
    err_set = stray || wb_miss || (rsv_vld && !d_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LATENCY_N; k++) slot_r[k] <= '0;
      cdb_r <= '0;
      err_r <= 1'b0;
    end else begin
      for (int k = 0; k <= LATENCY_N; k++) slot_r[k] <= slot_nxt[k];
      cdb_r.vld <= wb_hit;
      if (wb_hit) begin
        cdb_r.tag   <= wb_tag[own];
        cdb_r.wdata <= wb_wdata[own];
      end
      if (err_set) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Directed bench for tomasulo_cdb_arb: functional units are modelled by a booking pipe that
// drives each expected owner's writeback on its cycle; broadcasts are checked against tables.
module tb_tomasulo_cdb_arb;
  import tomasulo_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  cdb_req;
  logic [3:0]  cdb_gnt;
  logic        rsv_vld;
  logic [1:0]  rsv_dly;
  logic        rsv_ack;
  logic [4:0]  wb_vld;
  tag_t        wb_tag   [5];
  word_t       wb_wdata [5];
  sch_t        sch_r;
  cdb_t        cdb_r;
  logic        err_r;

  int checks = 0;
  int errors = 0;
  int pipe [4];

  tag_t  tag_tab  [5] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd9};
  word_t data_tab [5] = '{32'hA0A0, 32'hB1B1, 32'hDEAD, 32'hC3C3, 32'hE4E4};

  tomasulo_cdb_arb dut (
    .clk      (clk),
    .rst      (rst),
    .cdb_req  (cdb_req),
    .cdb_gnt  (cdb_gnt),
    .rsv_vld  (rsv_vld),
    .rsv_dly  (rsv_dly),
    .rsv_ack  (rsv_ack),
    .wb_vld   (wb_vld),
    .wb_tag   (wb_tag),
    .wb_wdata (wb_wdata),
    .sch_r    (sch_r),
    .cdb_r    (cdb_r),
    .err_r    (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic cdb_t exp_bc(input logic [2:0] u);
    cdb_t c;
    c.vld   = 1'b1;
    c.tag   = tag_tab[u];
    c.wdata = data_tab[u];
    return c;
  endfunction

  task automatic drive_wb();
    logic [2:0] u;
    wb_vld = '0;
    for (int j = 0; j < 5; j++) begin
      wb_tag[j]   = '0;
      wb_wdata[j] = '0;
    end
    if (pipe[0] >= 0) begin
      u           = 3'(pipe[0]);
      wb_vld[u]   = 1'b1;
      wb_tag[u]   = tag_tab[u];
      wb_wdata[u] = data_tab[u];
    end
  endtask

  task automatic book(input int u, input int d);
    pipe[d] = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) pipe[k] = pipe[k+1];
    pipe[3] = -1;
    drive_wb();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cdb_req = '0;
    rsv_vld = 1'b0;
    rsv_dly = '0;
    for (int k = 0; k < 4; k++) pipe[k] = -1;
    drive_wb();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_sch", 64'(sch_r), 64'd0);
    chk("rst_cdb", 64'(cdb_r), 64'd0);
    chk("rst_err", 64'(err_r), 64'd0);
    chk("rst_gnt", 64'(cdb_gnt), 64'd0);
    chk("rst_ack", 64'(rsv_ack), 64'd0);

    // Single request from station 2
    do_reset();
    cdb_req = 4'b0100; #1;
    chk("single_gnt", 64'(cdb_gnt), 64'h4);
    book(2, 2);
    step(); cdb_req = '0; #1;
    chk("single_sch_t1", 64'(sch_r), 64'b010);
    step(); #1;
    chk("single_sch_t2", 64'(sch_r), 64'b001);
    step(); #1;
    chk("single_bc", 64'(cdb_r), 64'(exp_bc(3'd2)));
    step(); #1;
    chk("single_vld_drop", 64'(cdb_r.vld), 64'd0);
    chk("single_tag_hold", 64'(cdb_r.tag), 64'd5);
    chk("single_err", 64'(err_r), 64'd0);

    // Round-robin fairness under saturation
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cdb_req = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (i < 8) begin
        chk("rr_gnt", 64'(cdb_gnt), 64'd1 << (i % 4));
        book(i % 4, 2);
      end
      if (i >= 3) chk("rr_bc", 64'(cdb_r), 64'(exp_bc(3'((i - 3) % 4))));
      step();
    end
    #1;
    chk("rr_err", 64'(err_r), 64'd0);

    // External reservation wins a shared slot; busy near slot refuses d=1
    do_reset();
    rsv_vld = 1'b1; rsv_dly = 2'd2; cdb_req = 4'b0001; #1;
    chk("ext_ack", 64'(rsv_ack), 64'd1);
    chk("ext_gnt_blocked", 64'(cdb_gnt), 64'd0);
    book(4, 2);
    step(); rsv_vld = 1'b1; rsv_dly = 2'd1; #1;
    chk("ext_busy_nack", 64'(rsv_ack), 64'd0);
    chk("ext_st0_gnt", 64'(cdb_gnt), 64'h1);
    book(0, 2);
    step(); rsv_vld = 1'b0; cdb_req = '0;
    step(); #1;
    chk("ext_bc", 64'(cdb_r), 64'(exp_bc(3'd4)));
    step(); #1;
    chk("ext_st0_bc", 64'(cdb_r), 64'(exp_bc(3'd0)));
    chk("ext_err", 64'(err_r), 64'd0);

    // Far reservation (d = LATENCY_N+1) blocks the station slot next cycle
    do_reset();
    rsv_vld = 1'b1; rsv_dly = 2'd3; #1;
    chk("far_ack", 64'(rsv_ack), 64'd1);
    book(4, 3);
    step(); rsv_vld = 1'b0; cdb_req = 4'b1111; #1;
    chk("far_sch", 64'(sch_r), 64'b100);
    chk("far_gnt_blocked", 64'(cdb_gnt), 64'd0);
    step(); #1;
    chk("far_gnt_resume", 64'(cdb_gnt), 64'h1);
    book(0, 2);
    step(); cdb_req = '0;
    step(); #1;
    chk("far_ext_bc", 64'(cdb_r), 64'(exp_bc(3'd4)));
    step(); #1;
    chk("far_st0_bc", 64'(cdb_r), 64'(exp_bc(3'd0)));
    chk("far_err", 64'(err_r), 64'd0);

    // Owner omits its writeback
    do_reset();
    cdb_req = 4'b0010; #1;
    chk("miss_gnt", 64'(cdb_gnt), 64'h2);
    step(); cdb_req = '0;
    step();
    step(); #1;
    chk("miss_no_bc", 64'(cdb_r.vld), 64'd0);
    chk("miss_err", 64'(err_r), 64'd1);
    step(); step(); #1;
    chk("miss_err_sticky", 64'(err_r), 64'd1);

    // Stray writeback from a non-owner
    do_reset();
    #1;
    chk("stray_err_clear", 64'(err_r), 64'd0);
    wb_vld[3] = 1'b1; wb_tag[3] = tag_tab[3]; wb_wdata[3] = data_tab[3];
    step(); #1;
    chk("stray_err", 64'(err_r), 64'd1);
    chk("stray_no_bc", 64'(cdb_r.vld), 64'd0);

    // Illegal reservation depth
    do_reset();
    rsv_vld = 1'b1; rsv_dly = 2'd0; #1;
    chk("illegal_nack", 64'(rsv_ack), 64'd0);
    step(); rsv_vld = 1'b0; #1;
    chk("illegal_err", 64'(err_r), 64'd1);
    chk("illegal_sch", 64'(sch_r), 64'd0);

    // Asynchronous reset mid-flight drops the booking and rewinds the pointer
    do_reset();
    cdb_req = 4'b0010; #1;
    chk("mid_gnt", 64'(cdb_gnt), 64'h2);
    step(); cdb_req = '0; #1;
    chk("mid_sch_t1", 64'(sch_r), 64'b010);
    rst = 1'b1; #1;
    chk("mid_sch_async", 64'(sch_r), 64'd0);
    rst = 1'b0;
    step();
    step(); #1;
    chk("mid_no_bc", 64'(cdb_r.vld), 64'd0);
    chk("mid_err", 64'(err_r), 64'd0);
    cdb_req = 4'b1111; #1;
    chk("mid_ptr_rewind", 64'(cdb_gnt), 64'h1);
    cdb_req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
